// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width defaults and Gray/binary conversions
// used by both the write-side and read-side pointer managers.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int PTR_MAX_W   = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs decode correctly because leading zero Gray bits stay zero.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-domain bundle between producer, RAM, read-pointer synchronizer and the
// write-pointer manager.
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
);

  logic              wr_en;
  logic              clr_overflow;
  logic [ADDR_W:0]   rd_gray_sync;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;

  modport master (
    output wr_en, clr_overflow, rd_gray_sync,
    input  mem_we, wr_addr, wr_gray, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, clr_overflow, rd_gray_sync,
    output mem_we, wr_addr, wr_gray, full, almost_full, wr_level, overflow
  );

endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer manager: binary RAM address, registered Gray
// pointer for the read domain, and full/almost_full/level/overflow status.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = FIFO_ADDR_W,
  parameter int AFULL_THRESH = 12
) (
  input logic             clk,
  input logic             rst_n,
  fifo_wptr_full_if.slave bus
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wbin_r;
  logic [PTR_W-1:0] wgray_r;
  logic [PTR_W-1:0] level_r;
  logic             full_r;
  logic             afull_r;
  logic             ovf_r;

  logic             push_s;
  logic [PTR_W-1:0] wbin_next_s;
  logic [PTR_W-1:0] wgray_next_s;
  logic [PTR_W-1:0] rbin_sync_s;
  logic [PTR_W-1:0] full_gray_s;
  logic [PTR_W-1:0] level_next_s;
  logic             full_next_s;
  logic             afull_next_s;
  logic             ovf_next_s;

  // Accepted push; gated by rst_n so nothing reaches the RAM while held in reset.
  assign push_s = bus.wr_en & ~full_r & rst_n;

  // Next-state pointer, status and sticky-overflow computation.
  always_comb begin
    wbin_next_s  = wbin_r + {{ADDR_W{1'b0}}, push_s};
    wgray_next_s = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next_s)));
    rbin_sync_s  = PTR_W'(gray2bin(PTR_MAX_W'(bus.rd_gray_sync)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_gray_s  = {~bus.rd_gray_sync[ADDR_W:ADDR_W-1], bus.rd_gray_sync[ADDR_W-2:0]};
    full_next_s  = (wgray_next_s == full_gray_s);
    level_next_s = wbin_next_s - rbin_sync_s;
    afull_next_s = (level_next_s >= AFULL_LVL);
    if (bus.wr_en & full_r) begin
      ovf_next_s = 1'b1;
    end else if (bus.clr_overflow) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // State registers; the Gray pointer must come straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_r  <= {PTR_W{1'b0}};
      wgray_r <= {PTR_W{1'b0}};
      level_r <= {PTR_W{1'b0}};
      full_r  <= 1'b0;
      afull_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      wbin_r  <= wbin_next_s;
      wgray_r <= wgray_next_s;
      level_r <= level_next_s;
      full_r  <= full_next_s;
      afull_r <= afull_next_s;
      ovf_r   <= ovf_next_s;
    end
  end

  assign bus.mem_we      = push_s;
  assign bus.wr_addr     = wbin_r[ADDR_W-1:0];
  assign bus.wr_gray     = wgray_r;
  assign bus.full        = full_r;
  assign bus.almost_full = afull_r;
  assign bus.wr_level    = level_r;
  assign bus.overflow    = ovf_r;

endmodule
